// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction-fetch front end: fetch PC, imem req/ack, instruction FIFO
// Purpose: owns the fetch PC, issues one word request at a time to instruction memory and
//    buffers returned words with their PC for decode. Redirects from execute flush the buffer
//    and retarget the fetch stream; a request already in flight is drained and discarded.
// Ports:
//    clk, rst                 clock and asynchronous active-high reset
//    imem_req/addr/ack/rdata  instruction memory handshake (addr word aligned)
//    redirect, redirect_pc    one-cycle redirect pulse and new fetch target
//    inst_valid/inst/inst_pc  head of instruction buffer towards decode
//    inst_ready               decode consumes head this cycle
//    pc_next                  next address to be requested
//    fault                    sticky misaligned-redirect fault
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> fault + HALT)
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic [31:0] pc_next,
   output logic        fault
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1  = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;
   state_t state_q, state_d;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      drain_addr_q, drain_addr_d;
   logic [31:0]      fifo_inst_q [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q, cnt_after_pop;
   logic             push, pop, flush, halt_set;
   logic [31:0]      target_pc;
   logic             bad_target;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   assign target_pc  = redirect_pc;
   assign bad_target = (redirect_pc[1:0] != 2'b00);
   assign fault      = fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           fault_q <= 1'b0;
      else if (halt_set) fault_q <= 1'b1;
   end
`else
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign target_pc  = {redirect_pc[31:2], 2'b00};
   assign bad_target = 1'b0;
   assign fault      = 1'b0;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // In DRAIN the in-flight address must stay on the bus while pc_next already holds the target.
   assign imem_req   = (state_q == REQ) || (state_q == DRAIN);
   assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
   assign pc_next    = pc_q;
   assign inst_valid = (count_q != '0);
   assign inst       = fifo_inst_q[rd_ptr_q];
   assign inst_pc    = fifo_pc_q[rd_ptr_q];

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      drain_addr_d  = drain_addr_q;
      push          = 1'b0;
      flush         = 1'b0;
      halt_set      = 1'b0;
      pop           = inst_valid && inst_ready;
      cnt_after_pop = count_q - CNT_W'(pop);

      case (state_q)
         // Using the post-pop count lets a freed slot re-issue the request on the next cycle.
         IDLE: if (cnt_after_pop < DEPTH_C) state_d = REQ;
         REQ: begin
            if (imem_ack) begin
               push    = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = (cnt_after_pop < DEPTH_M1) ? REQ : IDLE;
            end
         end
         DRAIN: if (imem_ack) state_d = REQ;
         HALT:  state_d = HALT;
         default: state_d = IDLE;
      endcase

      // Redirect overrides the normal flow: ack data in this cycle is dropped with the flush.
      if (redirect && (state_q != HALT)) begin
         flush = 1'b1;
         push  = 1'b0;
         if (bad_target) begin
            halt_set = 1'b1;
            state_d  = HALT;
         end else begin
            pc_d = target_pc;
            case (state_q)
               REQ: begin
                  if (imem_ack) begin
                     state_d = REQ;
                  end else begin
                     state_d      = DRAIN;
                     drain_addr_d = pc_q;
                  end
               end
               DRAIN:   state_d = imem_ack ? REQ : DRAIN;
               default: state_d = REQ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_inst_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst_w;
   logic        imem_req, imem_ack, redirect, inst_valid, inst_ready, fault;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc, pc_next;
   logic        ack_en;

   logic        req_w, ack_w, valid_w, fault_w;
   logic [31:0] addr_w, rdata_w, inst_w, inst_pc_w, pc_next_w;

   int errors = 0;
   int checks = 0;

   assign imem_ack   = imem_req && ack_en;
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
   assign ack_w      = req_w;
   assign rdata_w    = addr_w ^ 32'hA5A5_0000;

   mips_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .pc_next(pc_next), .fault(fault)
   );

   mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
      .clk(clk), .rst(rst_w),
      .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
      .redirect(1'b0), .redirect_pc(32'h0),
      .inst_valid(valid_w), .inst(inst_w), .inst_pc(inst_pc_w), .inst_ready(1'b1),
      .pc_next(pc_next_w), .fault(fault_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rst_w = 1'b1; ack_en = 1'b1; inst_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0;
      step(); step();

      // reset state
      chk("rst_req",   {31'b0, imem_req},   32'h0);
      chk("rst_addr",  imem_addr,           32'h0);
      chk("rst_pc",    pc_next,             32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst",  inst,                32'h0);
      chk("rst_ipc",   inst_pc,             32'h0);
      chk("rst_fault", {31'b0, fault},      32'h0);
      chk("rstw_pc",   pc_next_w,           32'hFFFF_FFF8);
      chk("rstw_req",  {31'b0, req_w},      32'h0);

      // free run: ack every cycle, decode always ready
      rst = 1'b0;
      step();
      chk("fr_req1",   {31'b0, imem_req},   32'h1);
      chk("fr_addr1",  imem_addr,           32'h0);
      chk("fr_valid0", {31'b0, inst_valid}, 32'h0);
      step();
      for (int k = 0; k < 6; k++) begin
         chk("fr_valid", {31'b0, inst_valid}, 32'h1);
         chk("fr_ipc",   inst_pc,             32'(4 * k));
         chk("fr_inst",  inst,                32'(4 * k) ^ 32'hA5A5_0000);
         step();
      end

      // reset while a request is outstanding drops req at once
      rst = 1'b1;
      #1;
      chk("rst_mid_req", {31'b0, imem_req}, 32'h0);

      // backpressure: FIFO fills with two entries and fetch stops
      inst_ready = 1'b0;
      step();
      rst = 1'b0;
      step(); step(); step();
      repeat (10) step();
      chk("bp_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_req",   {31'b0, imem_req},   32'h0);
      chk("bp_pc",    pc_next,             32'h8);
      chk("bp_ipc0",  inst_pc,             32'h0);
      inst_ready = 1'b1;
      step();
      chk("bp_ipc4",  inst_pc,             32'h4);
      chk("bp_rereq", {31'b0, imem_req},   32'h1);
      chk("bp_raddr", imem_addr,           32'h8);
      step();
      chk("bp_ipc8",  inst_pc,             32'h8);

      // redirect while a request waits for a delayed ack
      rst = 1'b1;
      step();
      ack_en = 1'b0;
      rst = 1'b0;
      step();
      chk("dr_req",  {31'b0, imem_req}, 32'h1);
      chk("dr_addr", imem_addr,         32'h0);
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      chk("dr_hold_req",  {31'b0, imem_req},   32'h1);
      chk("dr_hold_addr", imem_addr,           32'h0);
      chk("dr_pc",        pc_next,             32'h100);
      chk("dr_valid",     {31'b0, inst_valid}, 32'h0);
      step(); step();
      chk("dr_wait_addr", imem_addr,           32'h0);
      ack_en = 1'b1;
      step();
      chk("dr_new_addr",  imem_addr,           32'h100);
      chk("dr_new_req",   {31'b0, imem_req},   32'h1);
      chk("dr_no_stale",  {31'b0, inst_valid}, 32'h0);
      step();
      chk("dr_first_v",   {31'b0, inst_valid}, 32'h1);
      chk("dr_first_pc",  inst_pc,             32'h100);
      chk("dr_first_i",   inst,                32'hA5A5_0100);

      // redirect coincident with ack, push and pop
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("co_valid", {31'b0, inst_valid}, 32'h0);
      chk("co_addr",  imem_addr,           32'h200);
      chk("co_pc",    pc_next,             32'h200);
      step();
      chk("co_v2",    {31'b0, inst_valid}, 32'h1);
      chk("co_ipc",   inst_pc,             32'h200);
      chk("co_inst",  inst,                32'hA5A5_0200);

      // misaligned redirect target
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("al_fault", {31'b0, fault},      32'h1);
      chk("al_req",   {31'b0, imem_req},   32'h0);
      chk("al_valid", {31'b0, inst_valid}, 32'h0);
      repeat (3) step();
      chk("al_fault_hold", {31'b0, fault},      32'h1);
      chk("al_req_hold",   {31'b0, imem_req},   32'h0);
      chk("al_valid_hold", {31'b0, inst_valid}, 32'h0);
      rst = 1'b1;
      #1;
      chk("al_fault_clr", {31'b0, fault}, 32'h0);
      step();
      rst = 1'b0;
`else
      chk("al_fault", {31'b0, fault},      32'h0);
      chk("al_pc",    pc_next,             32'h100);
      chk("al_addr",  imem_addr,           32'h100);
      chk("al_valid", {31'b0, inst_valid}, 32'h0);
      step();
      chk("al_v2",    {31'b0, inst_valid}, 32'h1);
      chk("al_ipc",   inst_pc,             32'h100);
`endif

      // PC wrap from RESET_PC = FFFF_FFF8
      rst_w = 1'b0;
      step();
      chk("wr_req",  {31'b0, req_w}, 32'h1);
      chk("wr_addr", addr_w,         32'hFFFF_FFF8);
      step();
      chk("wr_ipc0", inst_pc_w,      32'hFFFF_FFF8);
      step();
      chk("wr_ipc1", inst_pc_w,      32'hFFFF_FFFC);
      chk("wr_pc",   pc_next_w,      32'h0);
      step();
      chk("wr_ipc2", inst_pc_w,      32'h0);
      chk("wr_inst", inst_w,         32'hA5A5_0000);
      chk("wr_fault", {31'b0, fault_w}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
